// File: rtl/vram_blit_engine.sv
// Local-bus rectangle fill/copy initiator for the 320x180 8-bit HDMI frame buffer.
// Issues CPU-style byte writes and byte reads in raster order while holding busy.
module vram_blit_engine #(
   parameter int                XLEN      = 32,
   parameter logic [XLEN-1:0]   VRAM_BASE = 32'h0020_0000,
   parameter int                H_PIX     = 320,
   parameter int                V_PIX     = 180,
   parameter int                RD_LAT    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            op,
   input  logic [8:0]      dst_x,
   input  logic [7:0]      dst_y,
   input  logic [8:0]      src_x,
   input  logic [7:0]      src_y,
   input  logic [8:0]      width,
   input  logic [7:0]      height,
   input  logic [7:0]      color,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            m_sel,
   output logic [XLEN-1:0] m_addr,
   output logic [2:0]      m_we,
   output logic [XLEN-1:0] m_qin,
   input  logic [XLEN-1:0] m_qout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_FILL  = 3'd2;
   localparam logic [2:0] S_RD    = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_WR    = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]      state_q, state_d;
   logic            op_q, op_d;
   logic [8:0]      dst_x_q, dst_x_d, src_x_q, src_x_d, w_q, w_d, x_q, x_d;
   logic [7:0]      dst_y_q, dst_y_d, src_y_q, src_y_d, h_q, h_d, y_q, y_d;
   logic [7:0]      color_q, color_d, wait_q, wait_d;
   logic [XLEN-1:0] dst_row_q, dst_row_d, src_row_q, src_row_d;
   logic            last_q, last_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic            m_sel_q, m_sel_d;
   logic [2:0]      m_we_q, m_we_d;
   logic [XLEN-1:0] m_addr_q, m_addr_d, m_qin_q, m_qin_d;

   logic            adv, at_last, zero_size, oob;
   logic [9:0]      dx_end, dy_end, sx_end, sy_end;
   logic            unused_qout;

   assign unused_qout = ^m_qout[XLEN-1:8];

   // 10-bit sums so that e.g. 511+511 can never wrap back into range.
   assign dx_end    = {1'b0, dst_x_q} + {1'b0, w_q};
   assign sx_end    = {1'b0, src_x_q} + {1'b0, w_q};
   assign dy_end    = {2'b0, dst_y_q} + {2'b0, h_q};
   assign sy_end    = {2'b0, src_y_q} + {2'b0, h_q};
   assign zero_size = (w_q == 9'd0) || (h_q == 8'd0);
   assign oob       = (dx_end > 10'(H_PIX)) || (dy_end > 10'(V_PIX)) ||
                      (op_q && ((sx_end > 10'(H_PIX)) || (sy_end > 10'(V_PIX))));
   assign at_last   = (x_q == w_q - 9'd1) && (y_q == h_q - 8'd1);

   // NOTE: every *_d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dst_x_d   = dst_x_q;
      dst_y_d   = dst_y_q;
      src_x_d   = src_x_q;
      src_y_d   = src_y_q;
      w_d       = w_q;
      h_d       = h_q;
      color_d   = color_q;
      x_d       = x_q;
      y_d       = y_q;
      wait_d    = wait_q;
      dst_row_d = dst_row_q;
      src_row_d = src_row_q;
      last_d    = last_q;
      err_d     = err_q;
      m_sel_d   = 1'b0;
      m_we_d    = 3'b000;
      m_addr_d  = m_addr_q;
      m_qin_d   = m_qin_q;
      adv       = 1'b0;

      case (state_q)
         S_IDLE: if (start) begin
            state_d   = S_CHECK;
            op_d      = op;
            dst_x_d   = dst_x;
            dst_y_d   = dst_y;
            src_x_d   = src_x;
            src_y_d   = src_y;
            w_d       = width;
            h_d       = height;
            color_d   = color;
            x_d       = 9'd0;
            y_d       = 8'd0;
            last_d    = 1'b0;
            err_d     = 1'b0;
            // One-time setup multiply; per-pixel stepping is purely additive.
            dst_row_d = VRAM_BASE + XLEN'(dst_y) * XLEN'(H_PIX) + XLEN'(dst_x);
            src_row_d = VRAM_BASE + XLEN'(src_y) * XLEN'(H_PIX) + XLEN'(src_x);
         end
         S_CHECK: begin
            if (zero_size) begin
               state_d = S_DONE;
            end else if (oob) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (!op_q) begin
               state_d  = S_FILL;
               m_sel_d  = 1'b1;
               m_we_d   = 3'b100;
               m_addr_d = dst_row_q + XLEN'(x_q);
               m_qin_d  = XLEN'(color_q);
               adv      = 1'b1;
            end else begin
               state_d  = S_RD;
               m_sel_d  = 1'b1;
               m_addr_d = src_row_q + XLEN'(x_q);
            end
         end
         S_FILL: begin
            if (last_q) begin
               state_d = S_DONE;
            end else begin
               m_sel_d  = 1'b1;
               m_we_d   = 3'b100;
               m_addr_d = dst_row_q + XLEN'(x_q);
               m_qin_d  = XLEN'(color_q);
               adv      = 1'b1;
            end
         end
         S_RD: begin
            state_d = S_WAIT;
            wait_d  = 8'd0;
         end
         S_WAIT: begin
            if (wait_q == 8'(RD_LAT - 1)) begin
               state_d  = S_WR;
               m_sel_d  = 1'b1;
               m_we_d   = 3'b100;
               m_addr_d = dst_row_q + XLEN'(x_q);
               m_qin_d  = XLEN'(m_qout[7:0]);
               adv      = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WR: begin
            if (last_q) begin
               state_d = S_DONE;
            end else begin
               state_d  = S_RD;
               m_sel_d  = 1'b1;
               m_addr_d = src_row_q + XLEN'(x_q);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         last_d = at_last;
         if (x_q == w_q - 9'd1) begin
            x_d       = 9'd0;
            y_d       = y_q + 8'd1;
            dst_row_d = dst_row_q + XLEN'(H_PIX);
            src_row_d = src_row_q + XLEN'(H_PIX);
         end else begin
            x_d = x_q + 9'd1;
         end
      end

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= 1'b0;
         dst_x_q   <= '0;
         dst_y_q   <= '0;
         src_x_q   <= '0;
         src_y_q   <= '0;
         w_q       <= '0;
         h_q       <= '0;
         color_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         wait_q    <= '0;
         dst_row_q <= '0;
         src_row_q <= '0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         m_sel_q   <= 1'b0;
         m_we_q    <= 3'b000;
         m_addr_q  <= '0;
         m_qin_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dst_x_q   <= dst_x_d;
         dst_y_q   <= dst_y_d;
         src_x_q   <= src_x_d;
         src_y_q   <= src_y_d;
         w_q       <= w_d;
         h_q       <= h_d;
         color_q   <= color_d;
         x_q       <= x_d;
         y_q       <= y_d;
         wait_q    <= wait_d;
         dst_row_q <= dst_row_d;
         src_row_q <= src_row_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         m_sel_q   <= m_sel_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_qin_q   <= m_qin_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign m_sel  = m_sel_q;
   assign m_we   = m_we_q;
   assign m_addr = m_addr_q;
   assign m_qin  = m_qin_q;

endmodule
